// File: rtl/predecode_fifo.sv
// Instruction buffer between fetch and issue: each MIPS32 word is pre-decoded on push
// and stored with its class, GPR-write and exception bits so issue reads ready-made controls.
module predecode_fifo #(
    parameter int DEPTH            = 8,
    parameter bit PAIR_BRANCH_SLOT = 1'b1,
    parameter int CNT_W            = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_pc,
    input  logic [31:0]      in_inst,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_pc,
    output logic [31:0]      out_inst,
    output logic [5:0]       out_class,
    output logic             out_rf_we,
    output logic [4:0]       out_rf_waddr,
    output logic [3:0]       out_exc,
    output logic             out_slot_valid,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    localparam logic [5:0] CLS_ALU    = 6'b000001;
    localparam logic [5:0] CLS_BRANCH = 6'b000010;
    localparam logic [5:0] CLS_LOAD   = 6'b000100;
    localparam logic [5:0] CLS_STORE  = 6'b001000;
    localparam logic [5:0] CLS_HILO   = 6'b010000;
    localparam logic [5:0] CLS_CP0    = 6'b100000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [5:0]  cls;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [3:0]  exc;
    } entry_t;

    entry_t           mem [DEPTH];
    entry_t           in_ent;
    entry_t           head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             push;
    logic             pop;
    logic             empty;
    logic             hold;

    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [5:0] fn;
    logic       invalid;

    assign op = in_inst[31:26];
    assign rs = in_inst[25:21];
    assign rt = in_inst[20:16];
    assign rd = in_inst[15:11];
    assign fn = in_inst[5:0];

    always_comb begin
        in_ent          = '0;
        in_ent.pc       = in_pc;
        in_ent.inst     = in_inst;
        invalid         = 1'b0;
        case (op)
            6'h00: begin
                case (fn)
                    6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                    6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                    6'h26, 6'h27, 6'h2a, 6'h2b: begin
                        in_ent.cls      = CLS_ALU;
                        in_ent.rf_we    = 1'b1;
                        in_ent.rf_waddr = rd;
                    end
                    6'h08: in_ent.cls = CLS_BRANCH;
                    6'h09: begin
                        in_ent.cls      = CLS_BRANCH;
                        in_ent.rf_we    = 1'b1;
                        in_ent.rf_waddr = 5'd31;
                    end
                    6'h0c: in_ent.exc[0] = 1'b1;
                    6'h0d: in_ent.exc[3] = 1'b1;
                    6'h10, 6'h12: begin
                        in_ent.cls      = CLS_HILO;
                        in_ent.rf_we    = 1'b1;
                        in_ent.rf_waddr = rd;
                    end
                    6'h11, 6'h13, 6'h18, 6'h19, 6'h1a, 6'h1b: in_ent.cls = CLS_HILO;
                    default: invalid = 1'b1;
                endcase
            end
            6'h01: begin
                case (rt)
                    5'h00, 5'h01: in_ent.cls = CLS_BRANCH;
                    5'h10, 5'h11: begin
                        in_ent.cls      = CLS_BRANCH;
                        in_ent.rf_we    = 1'b1;
                        in_ent.rf_waddr = 5'd31;
                    end
                    default: invalid = 1'b1;
                endcase
            end
            6'h02, 6'h04, 6'h05, 6'h06, 6'h07: in_ent.cls = CLS_BRANCH;
            6'h03: begin
                in_ent.cls      = CLS_BRANCH;
                in_ent.rf_we    = 1'b1;
                in_ent.rf_waddr = 5'd31;
            end
            6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f: begin
                in_ent.cls      = CLS_ALU;
                in_ent.rf_we    = 1'b1;
                in_ent.rf_waddr = rt;
            end
            6'h10: begin
                if (rs == 5'h00) begin
                    in_ent.cls      = CLS_CP0;
                    in_ent.rf_we    = 1'b1;
                    in_ent.rf_waddr = rt;
                end else if (rs == 5'h04) begin
                    in_ent.cls = CLS_CP0;
                end else if (rs == 5'h10 && fn == 6'h18) begin
                    in_ent.cls    = CLS_CP0;
                    in_ent.exc[2] = 1'b1;
                end else begin
                    invalid = 1'b1;
                end
            end
            6'h1c: begin
                if (fn == 6'h02) begin
                    in_ent.cls      = CLS_HILO;
                    in_ent.rf_we    = 1'b1;
                    in_ent.rf_waddr = rd;
                end else begin
                    invalid = 1'b1;
                end
            end
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
                in_ent.cls      = CLS_LOAD;
                in_ent.rf_we    = 1'b1;
                in_ent.rf_waddr = rt;
            end
            6'h28, 6'h29, 6'h2b: in_ent.cls = CLS_STORE;
            default: invalid = 1'b1;
        endcase
        in_ent.exc[1] = invalid;
    end

    assign head  = mem[rd_ptr];
    assign empty = (cnt == '0);
    // A lone branch at the head waits for its delay slot to be buffered.
    assign hold  = PAIR_BRANCH_SLOT & head.cls[1] & (cnt < CNT_W'(2));

    assign in_ready       = ~rst & (cnt != CNT_W'(DEPTH));
    assign out_valid      = ~empty & ~hold;
    assign out_slot_valid = (cnt >= CNT_W'(2));
    assign push           = in_valid & in_ready;
    assign pop            = out_valid & out_ready;
    assign count          = cnt;

    assign out_pc       = empty ? '0 : head.pc;
    assign out_inst     = empty ? '0 : head.inst;
    assign out_class    = empty ? '0 : head.cls;
    assign out_rf_we    = empty ? 1'b0 : head.rf_we;
    assign out_rf_waddr = empty ? '0 : head.rf_waddr;
    assign out_exc      = empty ? '0 : head.exc;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[PTR_W'(i)] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_ent;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_predecode_fifo.sv
// Scoreboard bench for predecode_fifo: directed scenarios then randomized traffic,
// checked against a rule-table instruction model and a queue occupancy model.
module tb_predecode_fifo;

    localparam int DEPTH = 8;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      in_pc = '0;
    logic [31:0]      in_inst = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [31:0]      out_pc;
    logic [31:0]      out_inst;
    logic [5:0]       out_class;
    logic             out_rf_we;
    logic [4:0]       out_rf_waddr;
    logic [3:0]       out_exc;
    logic             out_slot_valid;
    logic [CNT_W-1:0] count;

    predecode_fifo #(.DEPTH(DEPTH), .PAIR_BRANCH_SLOT(1'b1), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
        .out_class(out_class), .out_rf_we(out_rf_we), .out_rf_waddr(out_rf_waddr),
        .out_exc(out_exc), .out_slot_valid(out_slot_valid), .count(count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endfunction

    // Instruction model: first matching (mask, match) rule defines the decode.
    typedef struct {
        logic [31:0] mask;
        logic [31:0] match;
        logic [5:0]  cls;
        int          dk;     // 0 none, 1 rd, 2 rt, 3 r31
        logic [3:0]  exc;
    } rule_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [5:0]  cls;
        logic        we;
        logic [4:0]  wa;
        logic [3:0]  exc;
    } ent_t;

    rule_t rules[$];
    ent_t  mq[$];

    function automatic void add(input logic [31:0] mask, input logic [31:0] match,
                                input logic [5:0] cls, input int dk, input logic [3:0] exc);
        rule_t r;
        r.mask = mask; r.match = match; r.cls = cls; r.dk = dk; r.exc = exc;
        rules.push_back(r);
    endfunction

    function automatic void build_rules();
        logic [5:0] r_alu [16] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h20, 6'h21,
                                   6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b};
        logic [5:0] r_hl [6] = '{6'h11, 6'h13, 6'h18, 6'h19, 6'h1a, 6'h1b};
        logic [5:0] i_br [5] = '{6'h02, 6'h04, 6'h05, 6'h06, 6'h07};
        logic [5:0] i_ld [5] = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25};
        logic [5:0] i_st [3] = '{6'h28, 6'h29, 6'h2b};
        foreach (r_alu[i]) add(32'hFC00003F, {26'd0, r_alu[i]}, 6'b000001, 1, 4'b0000);
        foreach (r_hl[i])  add(32'hFC00003F, {26'd0, r_hl[i]},  6'b010000, 0, 4'b0000);
        add(32'hFC00003F, 32'h00000008, 6'b000010, 0, 4'b0000);
        add(32'hFC00003F, 32'h00000009, 6'b000010, 3, 4'b0000);
        add(32'hFC00003F, 32'h0000000C, 6'b000000, 0, 4'b0001);
        add(32'hFC00003F, 32'h0000000D, 6'b000000, 0, 4'b1000);
        add(32'hFC00003F, 32'h00000010, 6'b010000, 1, 4'b0000);
        add(32'hFC00003F, 32'h00000012, 6'b010000, 1, 4'b0000);
        add(32'hFC1F0000, 32'h04000000, 6'b000010, 0, 4'b0000);
        add(32'hFC1F0000, 32'h04010000, 6'b000010, 0, 4'b0000);
        add(32'hFC1F0000, 32'h04100000, 6'b000010, 3, 4'b0000);
        add(32'hFC1F0000, 32'h04110000, 6'b000010, 3, 4'b0000);
        foreach (i_br[i]) add(32'hFC000000, {i_br[i], 26'd0}, 6'b000010, 0, 4'b0000);
        add(32'hFC000000, 32'h0C000000, 6'b000010, 3, 4'b0000);
        for (int op = 8; op < 16; op++) add(32'hFC000000, {6'(op), 26'd0}, 6'b000001, 2, 4'b0000);
        foreach (i_ld[i]) add(32'hFC000000, {i_ld[i], 26'd0}, 6'b000100, 2, 4'b0000);
        foreach (i_st[i]) add(32'hFC000000, {i_st[i], 26'd0}, 6'b001000, 0, 4'b0000);
        add(32'hFFE00000, 32'h40000000, 6'b100000, 2, 4'b0000);
        add(32'hFFE00000, 32'h40800000, 6'b100000, 0, 4'b0000);
        add(32'hFFE0003F, 32'h42000018, 6'b100000, 0, 4'b0100);
        add(32'hFC00003F, 32'h70000002, 6'b010000, 1, 4'b0000);
    endfunction

    function automatic ent_t model(input logic [31:0] pc, input logic [31:0] inst);
        ent_t e;
        e.pc = pc; e.inst = inst; e.cls = '0; e.we = 1'b0; e.wa = '0; e.exc = 4'b0010;
        foreach (rules[i]) begin
            if ((inst & rules[i].mask) == rules[i].match) begin
                e.cls = rules[i].cls;
                e.exc = rules[i].exc;
                e.we  = (rules[i].dk != 0);
                case (rules[i].dk)
                    1: e.wa = inst[15:11];
                    2: e.wa = inst[20:16];
                    3: e.wa = 5'd31;
                    default: e.wa = 5'd0;
                endcase
                break;
            end
        end
        return e;
    endfunction

    // Monitor: compare the DUT against the model, then advance the model to the next edge.
    bit   chk_en = 1'b0;
    int   m_cnt;
    logic m_valid;
    always @(negedge clk) begin
        m_cnt   = mq.size();
        m_valid = 1'b0;
        if (m_cnt > 0) m_valid = !(mq[0].cls[1] && m_cnt < 2);
        if (chk_en) begin
            chk("count", 32'(count), 32'(m_cnt));
            chk("in_ready", 32'(in_ready), 32'(!rst && m_cnt != DEPTH));
            chk("out_valid", 32'(out_valid), 32'(m_valid));
            chk("out_slot_valid", 32'(out_slot_valid), 32'(m_cnt >= 2));
            if (m_cnt > 0) begin
                chk("head_pc", out_pc, mq[0].pc);
                chk("head_inst", out_inst, mq[0].inst);
                chk("head_class", 32'(out_class), 32'(mq[0].cls));
                chk("head_rf_we", 32'(out_rf_we), 32'(mq[0].we));
                chk("head_rf_waddr", 32'(out_rf_waddr), 32'(mq[0].wa));
                chk("head_exc", 32'(out_exc), 32'(mq[0].exc));
            end else begin
                chk("empty_data", out_pc | out_inst | 32'(out_class) | 32'(out_rf_we)
                                  | 32'(out_rf_waddr) | 32'(out_exc), 32'd0);
            end
        end
        if (rst) begin
            mq.delete();
            chk_en = 1'b1;
        end else if (flush) begin
            mq.delete();
        end else begin
            if (m_valid && out_ready) void'(mq.pop_front());
            if (in_valid && m_cnt < DEPTH) mq.push_back(model(in_pc, in_inst));
        end
    end

    task automatic step(input logic iv, input logic [31:0] pc, input logic [31:0] ins,
                        input logic ordy, input logic fl, input logic r);
        in_valid = iv; in_pc = pc; in_inst = ins; out_ready = ordy; flush = fl; rst = r;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 32'h0, 32'h0, ordy, 1'b0, 1'b0);
    endtask

    localparam logic [31:0] ADDIU   = 32'h24220005;
    localparam logic [31:0] JAL     = 32'h0C000010;
    localparam logic [31:0] BADOP   = 32'hFC000000;
    localparam logic [31:0] SYSCALL = 32'h0000000C;

    initial begin
        rule_t r;
        logic [31:0] ins;
        int ready_pct;
        build_rules();

        // Reset
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        chk("in_ready_during_rst", 32'(in_ready), 32'd0);
        idle(1'b0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_slot_valid", 32'(out_slot_valid), 32'd0);
        chk("rst_out_pc", out_pc, 32'd0);

        // addiu $2,$1,5
        step(1'b1, 32'hBFC00000, ADDIU, 1'b0, 1'b0, 1'b0);
        chk("addiu_valid", 32'(out_valid), 32'd1);
        chk("addiu_class", 32'(out_class), 32'b000001);
        chk("addiu_we", 32'(out_rf_we), 32'd1);
        chk("addiu_waddr", 32'(out_rf_waddr), 32'd2);
        chk("addiu_exc", 32'(out_exc), 32'd0);
        chk("addiu_count", 32'(count), 32'd1);
        idle(1'b1);
        chk("addiu_popped", 32'(count), 32'd0);

        // Fill to full, then a rejected ninth push, then drain across the wrap
        for (int i = 0; i < 9; i++) begin
            step(1'b1, 32'h1000 + 32'(4 * i), ADDIU, 1'b0, 1'b0, 1'b0);
            if (i == 7) begin
                chk("full_count", 32'(count), 32'd8);
                chk("full_in_ready", 32'(in_ready), 32'd0);
            end
        end
        chk("ninth_ignored", 32'(count), 32'd8);
        idle(1'b1);
        chk("drain_second_pc", out_pc, 32'h1004);
        for (int i = 0; i < 7; i++) idle(1'b1);
        chk("drain_count", 32'(count), 32'd0);

        // Branch held until its delay slot arrives
        step(1'b1, 32'h2000, JAL, 1'b1, 1'b0, 1'b0);
        chk("jal_alone_valid", 32'(out_valid), 32'd0);
        chk("jal_alone_count", 32'(count), 32'd1);
        step(1'b1, 32'h2004, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("jal_pair_valid", 32'(out_valid), 32'd1);
        chk("jal_pair_slot", 32'(out_slot_valid), 32'd1);
        chk("jal_waddr", 32'(out_rf_waddr), 32'd31);
        chk("jal_class", 32'(out_class), 32'b000010);
        idle(1'b1);
        chk("slot_head_pc", out_pc, 32'h2004);
        chk("slot_head_count", 32'(count), 32'd1);
        idle(1'b1);

        // Invalid opcode and syscall
        step(1'b1, 32'h3000, BADOP, 1'b0, 1'b0, 1'b0);
        chk("inv_exc", 32'(out_exc), 32'b0010);
        chk("inv_we", 32'(out_rf_we), 32'd0);
        chk("inv_class", 32'(out_class), 32'd0);
        chk("inv_valid", 32'(out_valid), 32'd1);
        step(1'b1, 32'h3004, SYSCALL, 1'b1, 1'b0, 1'b0);
        chk("sys_exc", 32'(out_exc), 32'b0001);
        chk("sys_count", 32'(count), 32'd1);
        idle(1'b1);

        // Flush beats simultaneous push and pop
        for (int i = 0; i < 5; i++) step(1'b1, 32'h4000 + 32'(4 * i), ADDIU, 1'b0, 1'b0, 1'b0);
        chk("pre_flush_count", 32'(count), 32'd5);
        step(1'b1, 32'h4100, ADDIU, 1'b1, 1'b1, 1'b0);
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_valid", 32'(out_valid), 32'd0);
        idle(1'b0);
        chk("flush_push_dropped", 32'(count), 32'd0);

        // Full with both handshakes: pop only, then the push lands
        for (int i = 0; i < 8; i++) step(1'b1, 32'h5000 + 32'(4 * i), ADDIU, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h5100, ADDIU, 1'b1, 1'b0, 1'b0);
        chk("full_pop_only", 32'(count), 32'd7);
        step(1'b1, 32'h5100, ADDIU, 1'b0, 1'b0, 1'b0);
        chk("full_refill", 32'(count), 32'd8);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1);
        chk("rst_flush_count", 32'(count), 32'd0);
        idle(1'b0);

        // Randomized traffic with alternating back-pressure
        for (int c = 0; c < 3000; c++) begin
            ready_pct = ((c / 200) % 2 == 0) ? 20 : 80;
            if ($urandom_range(0, 3) == 0) begin
                ins = $urandom;
            end else begin
                r   = rules[$urandom_range(0, rules.size() - 1)];
                ins = r.match | ($urandom & ~r.mask);
            end
            step($urandom_range(0, 99) < 60, $urandom, ins,
                 $urandom_range(0, 99) < ready_pct,
                 $urandom_range(0, 99) < 2,
                 $urandom_range(0, 199) == 0);
        end

        idle(1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/predecode_fifo.md
Name: predecode_fifo

Overview:
- Parametrised instruction buffer between fetch and issue. Pre-decodes each MIPS32 instruction at push, so issue reads ready-made control bits instead of decoding raw bits.
- Replaces the combinational-only decode stage with a DEPTH-entry queue carrying class, register-write and exception bits.
- Optional branch/delay-slot pairing holds a branch at the head until its delay slot is also buffered.

Parameters:
- DEPTH, 8, number of entries; power of two, at least 2.
- PAIR_BRANCH_SLOT, 1, 1 = head branch not issuable until its delay-slot entry is present.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  discard all entries (exception/eret/mispredict)
- in_valid  in  1  fetch presents instruction
- in_ready  out  1  buffer can accept
- in_pc  in  32  instruction address
- in_inst  in  32  instruction word
- out_valid  out  1  head entry issuable
- out_ready  in  1  issue consumes head
- out_pc  out  32  head pc
- out_inst  out  32  head instruction
- out_class  out  6  {cp0, hilo, store, load, branch, alu}, one-hot or zero
- out_rf_we  out  1  head writes GPR
- out_rf_waddr  out  5  head GPR destination
- out_exc  out  4  {break, eret, instinvalid, syscall}
- out_slot_valid  out  1  entry after head exists
- count  out  CNT_W  occupancy

Behaviour:
- Reset (rst=1 at a clk edge): pointers and count go to 0, all storage goes to 0. Following cycle: out_valid=0, out_slot_valid=0, in_ready=1, count=0, all out_* data=0.
- While rst is held, in_ready=0.
- Push: in_valid & in_ready at the clk edge. in_ready = (count != DEPTH); it does not depend on out_ready, so a full buffer cannot push and pop in the same cycle.
- Pop: out_valid & out_ready at the clk edge.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH.
- Pre-decode is combinational on in_inst and stored with the entry. Latency from push to out_valid is 1 cycle (no bypass).
- Class rules:
  - alu: arithmetic, logic, shift, slt*, lui.
  - branch: beq, bne, bgez, bgtz, blez, bltz, bgezal, bltzal, j, jal, jr, jalr.
  - load: lb, lbu, lh, lhu, lw.
  - store: sb, sh, sw.
  - hilo: mfhi, mflo, mthi, mtlo, mult, multu, div, divu, mul.
  - cp0: mfc0, mtc0, eret.
  - syscall and break: class 0.
- out_rf_we/out_rf_waddr rules:
  - rd: R-type alu, mfhi, mflo, mul.
  - rt: I-type alu, lui, loads, mfc0.
  - 31: jal, bgezal, bltzal, jalr.
  - Otherwise out_rf_we=0 and out_rf_waddr=0.
- Unrecognised opcode/func: instinvalid=1, class=0, rf_we=0. The entry is still stored and issued normally.
- out_valid = (count != 0) & ~(PAIR_BRANCH_SLOT & head.branch & count < 2).
- out_slot_valid = (count >= 2).
- Branch pop removes only the branch; its slot becomes head on the next cycle.
- When count = 0, all out_* data outputs are driven to 0.
- Flush: count and pointers go to 0 at the clk edge. Flush has priority over push and pop in the same cycle; the pushed instruction is dropped and no pop is credited.
- Flush while rst=1: reset dominates (identical result).
- A head branch held because its slot is missing does not block pushes.

Test Plan:
- Reset, then push addiu $2,$1,5 (0x24220005) at pc 0xBFC00000. Next cycle: out_valid=1, out_class=alu (000001), out_rf_we=1, out_rf_waddr=2, out_exc=0, count=1.
- Push 8 entries with out_ready=0 (DEPTH=8): count=8, in_ready=0. A 9th in_valid is ignored. Pop all with out_ready=1: entries come out in order, pc values match, pointers wrap, count returns to 0.
- PAIR_BRANCH_SLOT=1: push jal (0x0C000010) alone -> out_valid=0. Push nop -> out_valid=1, out_slot_valid=1, out_rf_waddr=31. Pop -> nop at head next cycle.
- Push 0xFC000000 (invalid) -> out_exc=0010, out_rf_we=0, out_class=0. Push syscall (0x0000000C) -> out_exc=0001.
- With count=5, assert flush, in_valid and out_ready in the same cycle -> next cycle count=0, out_valid=0, pushed instruction absent.
- Full buffer with out_ready=1 and in_valid=1 -> pop only, count=DEPTH-1. Next cycle push accepted and count returns to DEPTH.
